// File: rtl/ffs_result_buffer_if.sv
// Handshake bundle between the find-first-set pipeline, the result buffer and its consumer.
interface ffs_result_buffer_if #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned RESULT_W = 10
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                issue;
    logic                issue_ok;
    logic                ffs_valid;
    logic [RESULT_W-1:0] ffs_result;
    logic                out_valid;
    logic                out_ready;
    logic [RESULT_W-1:0] out_result;
    logic [CW-1:0]       count;
    logic [CW-1:0]       inflight;
    logic                err_overflow;
    logic                err_underflow;

    modport master (
        output issue, ffs_valid, ffs_result, out_ready,
        input  issue_ok, out_valid, out_result, count, inflight, err_overflow, err_underflow
    );

    modport slave (
        input  issue, ffs_valid, ffs_result, out_ready,
        output issue_ok, out_valid, out_result, count, inflight, err_overflow, err_underflow
    );
endinterface

// File: rtl/ffs_result_buffer.sv
// Credit-managed result FIFO behind the find-first-set pipeline; issue_ok reserves one slot
// per in-flight vector so pipeline results never have to be back-pressured.
module ffs_result_buffer #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned RESULT_W = 10
) (
    input logic                clk,
    input logic                reset,
    ffs_result_buffer_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [RESULT_W-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic          err_overflow_q, err_overflow_d;
    logic          err_underflow_q, err_underflow_d;

    logic          full;
    logic          pop;
    logic          wr;
    logic          drop;
    logic          credit_ok;
    logic [CW:0]   credit_used;

    always_comb begin
        full        = (count_q == CW'(DEPTH));
        pop         = (count_q != '0) & bus.out_ready;
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        wr          = bus.ffs_valid & (~full | pop);
        drop        = bus.ffs_valid & full & ~pop;
        credit_used = {1'b0, inflight_q} + {1'b0, count_q};
        credit_ok   = credit_used < (CW + 1)'(DEPTH);
    end

    always_comb begin
        wr_ptr_d = wr ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        if (wr && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !wr) begin
            count_d = count_q - CW'(1);
        end

        inflight_d = inflight_q;
        if (bus.issue && !bus.ffs_valid) begin
            inflight_d = inflight_q + CW'(1);
        end else if (bus.ffs_valid && !bus.issue && inflight_q != '0) begin
            inflight_d = inflight_q - CW'(1);
        end

        err_overflow_d  = err_overflow_q | (bus.issue & ~credit_ok) | drop;
        err_underflow_d = err_underflow_q |
                          (bus.ffs_valid & ~bus.issue & (inflight_q == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            inflight_q      <= '0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            inflight_q      <= inflight_d;
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    // Storage carries no reset; out_result is masked while empty instead.
    always_ff @(posedge clk) begin
        if (wr && !reset) begin
            mem[wr_ptr_q] <= bus.ffs_result;
        end
    end

    assign bus.issue_ok      = credit_ok;
    assign bus.out_valid     = (count_q != '0);
    assign bus.out_result    = (count_q != '0) ? mem[rd_ptr_q] : '0;
    assign bus.count         = count_q;
    assign bus.inflight      = inflight_q;
    assign bus.err_overflow  = err_overflow_q;
    assign bus.err_underflow = err_underflow_q;

endmodule

// File: tb/tb_ffs_result_buffer.sv
// Directed and randomized bench for ffs_result_buffer, checked against a queue-based model.
module tb_ffs_result_buffer;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned RESULT_W = 10;
    localparam int unsigned CW       = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ffs_result_buffer_if #(.DEPTH(DEPTH), .RESULT_W(RESULT_W)) bus ();

    ffs_result_buffer #(.DEPTH(DEPTH), .RESULT_W(RESULT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents as a queue, credit counter as an integer.
    logic [RESULT_W-1:0] m_q[$];
    int                  m_inflight;
    bit                  m_ovf;
    bit                  m_unf;
    logic [RESULT_W-1:0] dut_popped[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit iss, input bit fv,
                         input logic [RESULT_W-1:0] res, input bit rdy);
        int sz;
        bit pop;
        if (r) begin
            m_q.delete();
            m_inflight = 0;
            m_ovf      = 1'b0;
            m_unf      = 1'b0;
            return;
        end
        sz  = m_q.size();
        pop = (sz != 0) && rdy;
        if (iss && (m_inflight + sz >= int'(DEPTH))) m_ovf = 1'b1;
        if (iss && !fv) begin
            m_inflight = (m_inflight + 1) % (1 << CW);
        end else if (fv && !iss) begin
            if (m_inflight == 0) m_unf = 1'b1;
            else m_inflight--;
        end
        if (pop) void'(m_q.pop_front());
        if (fv) begin
            if (sz == int'(DEPTH) && !pop) m_ovf = 1'b1;
            else m_q.push_back(res);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = m_q.size();
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(sz != 0));
        chk({tag, ".out_result"}, 32'(bus.out_result), (sz != 0) ? 32'(m_q[0]) : 32'd0);
        chk({tag, ".count"}, 32'(bus.count), 32'(sz));
        chk({tag, ".inflight"}, 32'(bus.inflight), 32'(m_inflight));
        chk({tag, ".issue_ok"}, 32'(bus.issue_ok), 32'((m_inflight + sz) < int'(DEPTH)));
        chk({tag, ".err_overflow"}, 32'(bus.err_overflow), 32'(m_ovf));
        chk({tag, ".err_underflow"}, 32'(bus.err_underflow), 32'(m_unf));
    endtask

    task automatic step(input bit r, input bit iss, input bit fv,
                        input logic [RESULT_W-1:0] res, input bit rdy, input string tag);
        reset          = r;
        bus.issue      = iss;
        bus.ffs_valid  = fv;
        bus.ffs_result = res;
        bus.out_ready  = rdy;
        if (!r && bus.out_valid === 1'b1 && rdy) dut_popped.push_back(bus.out_result);
        model(r, iss, fv, res, rdy);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        int issued;
        int returned;

        // Reset state
        step(1, 0, 0, '0, 0, "rst0");
        step(1, 1, 1, 10'h3ff, 1, "rst1");
        chk("rst.issue_ok", 32'(bus.issue_ok), 32'd1);
        chk("rst.out_result", 32'(bus.out_result), 32'd0);
        step(0, 0, 0, '0, 0, "rst2");

        // Single result with pipeline latency
        step(0, 1, 0, '0, 0, "single.issue");
        chk("single.inflight1", 32'(bus.inflight), 32'd1);
        for (int i = 0; i < 9; i++) step(0, 0, 0, '0, 0, "single.wait");
        step(0, 0, 1, 10'h005, 0, "single.ret");
        chk("single.inflight0", 32'(bus.inflight), 32'd0);
        chk("single.head", 32'(bus.out_result), 32'h005);
        step(0, 0, 0, '0, 1, "single.pop");
        chk("single.count0", 32'(bus.count), 32'd0);

        // Credit exhaustion
        for (int i = 0; i < 16; i++) step(0, 1, 0, '0, 0, "credit.issue");
        chk("credit.issue_ok0", 32'(bus.issue_ok), 32'd0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, RESULT_W'(100 + i), 0, "credit.ret");
        chk("credit.count16", 32'(bus.count), 32'd16);
        chk("credit.noerr", 32'({bus.err_overflow, bus.err_underflow}), 32'd0);

        // Full FIFO: write with pop completes, write alone drops
        step(0, 0, 1, 10'd200, 1, "full.wrpop");
        chk("full.wrpop.count", 32'(bus.count), 32'd16);
        chk("full.wrpop.head", 32'(bus.out_result), 32'd101);
        chk("full.wrpop.noerr", 32'(bus.err_overflow), 32'd0);
        step(0, 0, 1, 10'd201, 0, "full.drop");
        chk("full.drop.ovf", 32'(bus.err_overflow), 32'd1);

        // Wrap-around: 40 results streamed through with toggling out_ready
        step(1, 0, 0, '0, 0, "wrap.rst");
        dut_popped.delete();
        issued   = 0;
        returned = 0;
        for (int cyc = 0; cyc < 400 && dut_popped.size() < 40; cyc++) begin
            bit iss;
            bit fv;
            iss = (issued < 40) && (m_inflight + m_q.size() < int'(DEPTH));
            fv  = (returned < issued) && ($urandom_range(0, 3) != 0);
            step(0, iss, fv, RESULT_W'(returned), cyc[0], "wrap");
            if (iss) issued++;
            if (fv) returned++;
        end
        chk("wrap.popped", 32'(dut_popped.size()), 32'd40);
        for (int k = 0; k < dut_popped.size(); k++) chk("wrap.order", 32'(dut_popped[k]), 32'(k));

        // Mid-operation reset, then late results
        step(1, 0, 0, '0, 0, "mid.rst0");
        for (int i = 0; i < 8; i++) step(0, 1, 0, '0, 0, "mid.issue");
        for (int i = 0; i < 5; i++) step(0, 0, 1, RESULT_W'(50 + i), 0, "mid.ret");
        chk("mid.count5", 32'(bus.count), 32'd5);
        chk("mid.inflight3", 32'(bus.inflight), 32'd3);
        step(1, 1, 1, 10'd77, 1, "mid.rst");
        chk("mid.rst.count", 32'(bus.count), 32'd0);
        chk("mid.rst.inflight", 32'(bus.inflight), 32'd0);
        chk("mid.rst.out_valid", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, RESULT_W'(60 + i), 0, "mid.late");
        chk("mid.unf", 32'(bus.err_underflow), 32'd1);
        chk("mid.count3", 32'(bus.count), 32'd3);

        // Credit violation
        step(1, 0, 0, '0, 0, "viol.rst");
        for (int i = 0; i < 16; i++) step(0, 1, 0, '0, 0, "viol.issue");
        chk("viol.pre.ovf", 32'(bus.err_overflow), 32'd0);
        step(0, 1, 0, '0, 0, "viol.over");
        chk("viol.ovf", 32'(bus.err_overflow), 32'd1);
        chk("viol.inflight17", 32'(bus.inflight), 32'd17);

        // Randomized traffic with occasional resets
        step(1, 0, 0, '0, 0, "rnd.rst");
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) != 0), RESULT_W'($urandom_range(0, 1023)),
                 ($urandom_range(0, 2) == 0), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
